// File: rtl/sram_readback_display_pkg.sv
// Shared constants and types for the SRAM read-back display slice.
package sram_readback_display_pkg;

    // Number of multiplexed digits on the board display.
    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Index of the currently driven digit.
    typedef logic [1:0] digitIdx_t;

    // Active-low one-hot anode pattern for a given digit index.
    function automatic logic [NUM_DIGITS-1:0] anodeFor(input digitIdx_t idx);
        logic [NUM_DIGITS-1:0] oneHot;
        oneHot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        return ~oneHot;
    endfunction

endpackage

// File: rtl/sram_readback_display_hex7seg.sv
// Nibble to active-low seven-segment decoder ({g,f,e,d,c,b,a}); 'b' and 'd' lowercase.
module hex7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure lookup of the standard hex glyphs.
    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sram_readback_display.sv
// Captures the last SRAM read (address + data byte) at the falling edge of the
// read strobe and shows it on the 4-digit multiplexed seven-segment display:
// digit3 = address, digit2 = blank, digits1:0 = data byte in hex.
module sram_readback_display
    import sram_readback_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_strobe,
    input  logic                  read_mode,
    input  logic [1:0]            rd_addr,
    input  logic [7:0]            rd_data,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  valid
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic                  r_strobeD;
    logic                  r_armed;
    logic [1:0]            r_addrHold;
    logic [1:0]            r_addrQ;
    logic [7:0]            r_dataQ;
    logic                  r_valid;
    logic [CNT_W-1:0]      r_refreshCnt;
    digitIdx_t             r_digitIdx;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_capture;
    logic [3:0]            w_nibble;
    logic [6:0]            w_hexSeg;
    logic [6:0]            w_segNext;

    // A read completes the cycle after the strobe drops. r_armed blocks a strobe
    // that was already high when reset released: that read was cut short and its
    // data is not trustworthy, so the strobe must be seen low once first.
    assign w_capture = r_strobeD & ~read_strobe & r_armed;

    // Strobe history, arming and the address that was on the bus during the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobeD  <= 1'b0;
            r_armed    <= 1'b0;
            r_addrHold <= 2'b00;
        end else begin
            r_strobeD <= read_strobe;
            if (!read_strobe) begin
                r_armed <= 1'b1;
            end
            if (read_strobe) begin
                r_addrHold <= rd_addr;
            end
        end
    end

    // Capture registers; the latest completed read always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataQ <= 8'h00;
            r_addrQ <= 2'b00;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_dataQ <= rd_data;
            r_addrQ <= r_addrHold;
            r_valid <= 1'b1;
        end
    end

    // Refresh timer: each digit stays lit for REFRESH_DIV clocks, then the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refreshCnt <= '0;
            r_digitIdx   <= '0;
        end else if (r_refreshCnt == CNT_MAX) begin
            r_refreshCnt <= '0;
            r_digitIdx   <= r_digitIdx + 2'd1;
        end else begin
            r_refreshCnt <= r_refreshCnt + 1'b1;
        end
    end

    // Pick the nibble shown on the active digit (digit2 is always blank).
    always_comb begin
        w_nibble = 4'h0;
        case (r_digitIdx)
            2'd0:    w_nibble = r_dataQ[3:0];
            2'd1:    w_nibble = r_dataQ[7:4];
            2'd3:    w_nibble = {2'b00, r_addrQ};
            default: w_nibble = 4'h0;
        endcase
    end

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_hexSeg)
    );

    // Final glyph: blank on digit2, dashes until the first read lands.
    always_comb begin
        w_segNext = w_hexSeg;
        if (r_digitIdx == 2'd2) begin
            w_segNext = SEG_BLANK;
        end else if (!r_valid) begin
            w_segNext = SEG_DASH;
        end
    end

    // Registered pin drivers so anode and segments switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            r_seg <= w_segNext;
            r_dp  <= ~((r_digitIdx == 2'd3) & read_mode);
            r_an  <= anodeFor(r_digitIdx);
        end
    end

    assign seg   = r_seg;
    assign dp    = r_dp;
    assign an    = r_an;
    assign valid = r_valid;

endmodule

// File: tb/tb_sram_readback_display.sv
// Self-checking bench for sram_readback_display with a fast refresh (4 clk per digit).
module tb_sram_readback_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       readStrobe = 1'b0;
    logic       readMode = 1'b0;
    logic [1:0] rdAddr = 2'b00;
    logic [7:0] rdData = 8'h00;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       valid;

    int testsRun = 0;
    int failCount = 0;

    // Reference glyph table, active-low {g,f,e,d,c,b,a}.
    logic [6:0] hexGlyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] anodeOf [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Model state: what the display should know about completed reads.
    int         edgeCount;
    logic       mInRead, mReadArmed, mSawLow, mValid;
    logic [1:0] mLastAddr, mAddr;
    logic [7:0] mData;
    logic [6:0] expSeg;
    logic [3:0] expAn;
    logic       expDp, expValid;
    int         idx;

    sram_readback_display #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_strobe (readStrobe),
        .read_mode   (readMode),
        .rd_addr     (rdAddr),
        .rd_data     (rdData),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .valid       (valid)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Glyph the model expects for a digit given the captured contents.
    function automatic logic [6:0] glyphFor(input int d, input logic v, input logic [7:0] data, input logic [1:0] addr);
        if (d == 2) return 7'h7F;
        if (!v) return 7'h3F;
        if (d == 0) return hexGlyph[data % 16];
        if (d == 1) return hexGlyph[data / 16];
        return hexGlyph[addr];
    endfunction

    // Per-cycle model and compare: outputs after an edge reflect the digit and
    // captured data as they stood before that edge; valid reflects the edge itself.
    always @(posedge clk) begin
        if (rst) begin
            edgeCount  = 0;
            mInRead    = 1'b0;
            mReadArmed = 1'b0;
            mSawLow    = 1'b0;
            mValid     = 1'b0;
            mLastAddr  = 2'b00;
            mAddr      = 2'b00;
            mData      = 8'h00;
            expSeg     = 7'h7F;
            expAn      = 4'hF;
            expDp      = 1'b1;
            expValid   = 1'b0;
        end else begin
            idx    = (edgeCount / DIV) % 4;
            expSeg = glyphFor(idx, mValid, mData, mAddr);
            expAn  = anodeOf[idx];
            expDp  = !(idx == 3 && readMode);
            if (readStrobe) begin
                if (!mInRead) begin
                    mInRead    = 1'b1;
                    mReadArmed = mSawLow;
                end
                mLastAddr = rdAddr;
            end else begin
                if (mInRead && mReadArmed) begin
                    mData  = rdData;
                    mAddr  = mLastAddr;
                    mValid = 1'b1;
                end
                mInRead = 1'b0;
                mSawLow = 1'b1;
            end
            expValid  = mValid;
            edgeCount = edgeCount + 1;
        end
        #1;
        checkOutput("seg", {1'b0, seg}, {1'b0, expSeg});
        checkOutput("an", {4'h0, an}, {4'h0, expAn});
        checkOutput("dp", {7'h0, dp}, {7'h0, expDp});
        checkOutput("valid", {7'h0, valid}, {7'h0, expValid});
    end

    // Strobe a read: hold for highCycles, then drop it while presenting addrAtFall.
    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data, input int highCycles, input logic [1:0] addrAtFall);
        @(negedge clk);
        readStrobe = 1'b1;
        rdAddr     = addr;
        rdData     = data;
        repeat (highCycles) @(negedge clk);
        readStrobe = 1'b0;
        rdAddr     = addrAtFall;
    endtask

    // Bounded wait for a given anode pattern; sampled on the falling edge.
    task automatic waitAnode(input logic [3:0] target, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === target) found = 1'b1;
        end
        if (!found) checkOutput({name, "_timeout"}, {4'h0, an}, {4'h0, target});
    endtask

    task automatic checkDigit(input logic [3:0] target, input logic [6:0] glyph, input string name);
        waitAnode(target, name);
        checkOutput(name, {1'b0, seg}, {1'b0, glyph});
    endtask

    // Directed scenarios with hand-computed glyphs.
    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_seg", {1'b0, seg}, 8'h7F);
        checkOutput("reset_an", {4'h0, an}, 8'h0F);
        rst = 1'b0;
        checkDigit(4'b1110, 7'h3F, "idle_dash_d0");
        checkDigit(4'b1011, 7'h7F, "idle_blank_d2");
        checkDigit(4'b0111, 7'h3F, "idle_dash_d3");
        checkOutput("idle_valid", {7'h0, valid}, 8'h00);

        applyStimulus(2'd2, 8'hA5, 10, 2'd2);
        @(negedge clk);
        checkOutput("read_valid", {7'h0, valid}, 8'h01);
        checkDigit(4'b1110, 7'h12, "read_d0");
        checkDigit(4'b1101, 7'h08, "read_d1");
        checkDigit(4'b0111, 7'h24, "read_d3");

        applyStimulus(2'd1, 8'h5A, 5, 2'd3);
        repeat (2) @(negedge clk);
        checkDigit(4'b0111, 7'h79, "hold_d3");

        applyStimulus(2'd0, 8'h3C, 3, 2'd0);
        applyStimulus(2'd3, 8'hF0, 3, 2'd3);
        repeat (2) @(negedge clk);
        checkDigit(4'b1110, 7'h40, "b2b_d0");
        checkDigit(4'b1101, 7'h0E, "b2b_d1");
        checkDigit(4'b0111, 7'h30, "b2b_d3");

        readMode = 1'b1;
        waitAnode(4'b1110, "mode_sync");
        waitAnode(4'b0111, "mode_d3");
        checkOutput("mode_dp_d3", {7'h0, dp}, 8'h00);
        waitAnode(4'b1110, "mode_d0");
        checkOutput("mode_dp_d0", {7'h0, dp}, 8'h01);
        readMode = 1'b0;
        waitAnode(4'b1110, "nomode_sync");
        waitAnode(4'b0111, "nomode_d3");
        checkOutput("nomode_dp_d3", {7'h0, dp}, 8'h01);

        @(negedge clk);
        readStrobe = 1'b1;
        rdAddr     = 2'd2;
        rdData     = 8'h77;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_valid", {7'h0, valid}, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        readStrobe = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midrst_novalid", {7'h0, valid}, 8'h00);
        checkDigit(4'b1110, 7'h3F, "midrst_d0");
        checkDigit(4'b0111, 7'h3F, "midrst_d3");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
